// File: rtl/alu_operand_sequencer.sv
// alu_operand_sequencer
//
// Sequential front end for a combinational M-bit ALU. One press of `enter`
// advances one step. The first press loads operand A from data_in, the
// second loads operand B, and the third loads the 2-bit opcode. The block
// then spends one cycle in EXEC so the ALU can settle on the new opcode.
// After that it captures the ALU's Result and Flags and shows them until
// the next press. `undo` steps back one stage and never clears a register.
//
// Optional feature, controlled by the CHAIN_RESULT_EN macro:
//   defined   - enter in SHOW loads A with the captured result and jumps to
//               WAIT_B, so results can be accumulated.
//   undefined - enter in SHOW returns to WAIT_A and leaves A unchanged.
//
// Ports:
//   clk, reset         system clock, synchronous active-high reset
//   data_in [M]        operand / opcode source (opcode uses bits [1:0])
//   enter, undo        debounced levels; rising edges are detected here
//   alu_result [M]     Result from the ALU
//   alu_flags [5]      Flags from the ALU, {N,Z,C,V,P}
//   A, B [M], OpCode   registered operands and opcode driven to the ALU
//   result_q, flags_q  captured Result / Flags
//   display [M]        value for the display driver
//   phase [4]          one-hot {SHOW, WAIT_OP, WAIT_B, WAIT_A}, zero in EXEC
//   done               high while result_q/flags_q hold a fresh result
module alu_operand_sequencer #(
  parameter int M = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [M-1:0] data_in,
  input  logic         enter,
  input  logic         undo,
  input  logic [M-1:0] alu_result,
  input  logic [4:0]   alu_flags,
  output logic [M-1:0] A,
  output logic [M-1:0] B,
  output logic [1:0]   OpCode,
  output logic [M-1:0] result_q,
  output logic [4:0]   flags_q,
  output logic [M-1:0] display,
  output logic [3:0]   phase,
  output logic         done
);

  typedef enum logic [2:0] {
    S_WAIT_A  = 3'd0,
    S_WAIT_B  = 3'd1,
    S_WAIT_OP = 3'd2,
    S_EXEC    = 3'd3,
    S_SHOW    = 3'd4
  } state_t;

  state_t       state_reg;
  logic [M-1:0] a_reg;
  logic [M-1:0] b_reg;
  logic [1:0]   opcode_reg;
  logic [M-1:0] result_reg;
  logic [4:0]   flags_reg;
  logic         done_reg;

  // Two registered copies of each button: the first copy is the "current"
  // sample and the second is the "previous" sample. Both reset to 0, so a
  // button that is already high when reset releases still gives one event.
  logic enter_cur_reg, enter_prev_reg;
  logic undo_cur_reg,  undo_prev_reg;

  logic enter_ev, undo_ev;
  logic enter_go, undo_go;

  assign enter_ev = enter_cur_reg & ~enter_prev_reg;
  assign undo_ev  = undo_cur_reg  & ~undo_prev_reg;
  // Simultaneous enter and undo events are ambiguous, so both are dropped.
  assign enter_go = enter_ev & ~undo_ev;
  assign undo_go  = undo_ev  & ~enter_ev;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= S_WAIT_A;
      a_reg          <= '0;
      b_reg          <= '0;
      opcode_reg     <= '0;
      result_reg     <= '0;
      flags_reg      <= '0;
      done_reg       <= 1'b0;
      enter_cur_reg  <= 1'b0;
      enter_prev_reg <= 1'b0;
      undo_cur_reg   <= 1'b0;
      undo_prev_reg  <= 1'b0;
    end else begin
      enter_cur_reg  <= enter;
      enter_prev_reg <= enter_cur_reg;
      undo_cur_reg   <= undo;
      undo_prev_reg  <= undo_cur_reg;

      case (state_reg)
        S_WAIT_A: begin
          if (enter_go) begin
            a_reg     <= data_in;
            state_reg <= S_WAIT_B;
          end
        end
        S_WAIT_B: begin
          if (enter_go) begin
            b_reg     <= data_in;
            state_reg <= S_WAIT_OP;
          end else if (undo_go) begin
            state_reg <= S_WAIT_A;
          end
        end
        S_WAIT_OP: begin
          if (enter_go) begin
            opcode_reg <= data_in[1:0];
            state_reg  <= S_EXEC;
          end else if (undo_go) begin
            state_reg <= S_WAIT_B;
          end
        end
        S_EXEC: begin
          // The ALU has had this whole cycle to settle on the new opcode.
          // Any button events seen during this cycle are discarded.
          result_reg <= alu_result;
          flags_reg  <= alu_flags;
          done_reg   <= 1'b1;
          state_reg  <= S_SHOW;
        end
        S_SHOW: begin
          if (enter_go) begin
            done_reg <= 1'b0;
`ifdef CHAIN_RESULT_EN
            a_reg     <= result_reg;
            state_reg <= S_WAIT_B;
`else
            state_reg <= S_WAIT_A;
`endif
          end else if (undo_go) begin
            done_reg  <= 1'b0;
            state_reg <= S_WAIT_OP;
          end
        end
        default: state_reg <= S_WAIT_A;
      endcase
    end
  end

  assign A        = a_reg;
  assign B        = b_reg;
  assign OpCode   = opcode_reg;
  assign result_q = result_reg;
  assign flags_q  = flags_reg;
  assign done     = done_reg;

  always_comb begin
    phase   = 4'b0000;
    display = result_reg;
    case (state_reg)
      S_WAIT_A: begin
        phase   = 4'b0001;
        display = data_in;
      end
      S_WAIT_B: begin
        phase   = 4'b0010;
        display = data_in;
      end
      S_WAIT_OP: begin
        phase   = 4'b0100;
        display = {{(M-2){1'b0}}, data_in[1:0]};
      end
      S_SHOW: begin
        phase   = 4'b1000;
        display = result_reg;
      end
      default: begin
        phase   = 4'b0000;
        display = result_reg;
      end
    endcase
  end

endmodule

// File: tb/tb_alu_operand_sequencer.sv
module tb_alu_operand_sequencer;

  localparam int M = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic [M-1:0] data_in;
  logic         enter;
  logic         undo;
  logic [M-1:0] alu_result;
  logic [4:0]   alu_flags;
  logic [M-1:0] A, B;
  logic [1:0]   OpCode;
  logic [M-1:0] result_q;
  logic [4:0]   flags_q;
  logic [M-1:0] display;
  logic [3:0]   phase;
  logic         done;

  int n_compared = 0;
  int n_mismatched = 0;

  // Expected {result_q, flags_q} per completed operation.
  logic [12:0] exp_q[$];

  always #5 clk = ~clk;

  alu_operand_sequencer #(.M(M)) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .enter(enter), .undo(undo),
    .alu_result(alu_result), .alu_flags(alu_flags),
    .A(A), .B(B), .OpCode(OpCode), .result_q(result_q), .flags_q(flags_q),
    .display(display), .phase(phase), .done(done)
  );

  // Stand-in for the external combinational ALU, flags {N,Z,C,V,P}.
  logic [M:0] sum_w;
  always_comb begin
    alu_result = '0;
    alu_flags  = '0;
    sum_w      = '0;
    case (OpCode)
      2'b00: begin
        sum_w = {1'b0, A} - {1'b0, B};
        alu_result = sum_w[M-1:0];
        alu_flags[2] = (A < B);
        alu_flags[1] = (A[M-1] != B[M-1]) && (alu_result[M-1] != A[M-1]);
      end
      2'b01: begin
        sum_w = {1'b0, A} + {1'b0, B};
        alu_result = sum_w[M-1:0];
        alu_flags[2] = sum_w[M];
        alu_flags[1] = (A[M-1] == B[M-1]) && (alu_result[M-1] != A[M-1]);
      end
      2'b10: alu_result = A | B;
      default: alu_result = A & B;
    endcase
    alu_flags[4] = alu_result[M-1];
    alu_flags[3] = (alu_result == '0);
    alu_flags[0] = ^alu_result;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  // Monitor: every rising edge of done is one completed operation.
  logic done_prev = 1'b0;
  always @(negedge clk) begin
    if (done === 1'b1 && done_prev !== 1'b1) begin
      n_compared++;
      if (exp_q.size() == 0) begin
        n_mismatched++;
        $display("FAIL sb_unexpected: got result %0h flags %b with nothing expected", result_q, flags_q);
      end else begin
        logic [12:0] e;
        e = exp_q.pop_front();
        if ({result_q, flags_q} !== e) begin
          n_mismatched++;
          $display("FAIL sb_result: got result %0h flags %b expected result %0h flags %b",
                   result_q, flags_q, e[12:5], e[4:0]);
        end else begin
          $display("ok   sb_result: result %0h flags %b", result_q, flags_q);
        end
      end
    end
    done_prev = done;
  end

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1; enter = 1'b0; undo = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  // One enter press: high two cycles, low two cycles. Returns at edge+1.
  task automatic press(input logic [M-1:0] v);
    @(posedge clk); #1;
    data_in = v; enter = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    enter = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
  endtask

  // Opcode press with scoreboard push and an EXEC-timing check.
  task automatic press_op(input logic [1:0] op, input logic [7:0] er, input logic [4:0] ef);
    exp_q.push_back({er, ef});
    @(posedge clk); #1;
    data_in = {6'b0, op}; enter = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    check("exec_phase", 32'(phase), 32'h0);
    enter = 1'b0;
    @(posedge clk); #1;
    check("done_after_exec", 32'(done), 32'h1);
    @(posedge clk); #1;
  endtask

  task automatic press_undo();
    @(posedge clk); #1;
    undo = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    undo = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1; enter = 1'b0; undo = 1'b0; data_in = 8'hA5;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;

    check("rst_phase", 32'(phase), 32'h1);
    check("rst_regs", {8'(A), 8'(B), 2'(OpCode), 8'(result_q), 5'(flags_q), 1'(done)}, 32'h0);
    check("rst_display", 32'(display), 32'hA5);

    // WAIT_A ignores undo.
    press_undo();
    check("undo_in_wait_a", 32'(phase), 32'h1);

    // 5 - 3 = 2
    press(8'h05);
    press(8'h03);
    check("wait_op_display", 32'(display), 32'h03);
    press_op(2'b00, 8'h02, 5'b00001);
    check("show_phase", 32'(phase), 32'h8);
    check("show_display", 32'(display), 32'h02);
    check("ops_loaded", {16'(A), 8'(B), 8'(OpCode)}, {16'h05, 8'h03, 8'h00});

    press(8'hAA);
`ifdef CHAIN_RESULT_EN
    check("chain_phase", 32'(phase), 32'h2);
    check("chain_a", 32'(A), 32'h02);
    check("chain_done_clr", 32'(done), 32'h0);
    press(8'h04);
    press_op(2'b01, 8'h06, 5'b00000);
`else
    check("show_enter_phase", 32'(phase), 32'h1);
    check("show_enter_a", 32'(A), 32'h05);
    check("show_enter_done", 32'(done), 32'h0);
`endif

    do_reset();
    press(8'h7F);
    press(8'h01);
    press_op(2'b01, 8'h80, 5'b10011);
    // Undo in SHOW returns to WAIT_OP and clears done.
    press_undo();
    check("show_undo_phase", 32'(phase), 32'h4);
    check("show_undo_done", 32'(done), 32'h0);

    do_reset();
    press(8'h03);
    press(8'h05);
    press_op(2'b00, 8'hFE, 5'b10101);

    // Enter held for 10 cycles gives exactly one advance.
    do_reset();
    @(posedge clk); #1;
    data_in = 8'hF0; enter = 1'b1;
    repeat (10) @(posedge clk);
    #1 enter = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("hold_phase", 32'(phase), 32'h2);
    check("hold_a", 32'(A), 32'hF0);
    press(8'h0F);
    press_op(2'b11, 8'h00, 5'b01000);

    // Undo from WAIT_OP, reload B, then simultaneous enter+undo.
    do_reset();
    press(8'h11);
    press(8'h22);
    data_in = 8'hFF;
    #1 check("wait_op_display_mask", 32'(display), 32'h03);
    press_undo();
    check("undo_to_wait_b", 32'(phase), 32'h2);
    press(8'h09);
    check("reload_b", {16'(A), 16'(B)}, {16'h11, 16'h09});
    check("reload_phase", 32'(phase), 32'h4);
    @(posedge clk); #1;
    enter = 1'b1; undo = 1'b1;
    repeat (2) @(posedge clk);
    #1 enter = 1'b0; undo = 1'b0;
    repeat (2) @(posedge clk);
    #1 check("both_ignored", 32'(phase), 32'h4);

    // Reset while in EXEC: no result may appear.
    @(posedge clk); #1;
    data_in = 8'h01; enter = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    check("exec_before_reset", 32'(phase), 32'h0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; enter = 1'b0;
    data_in = 8'h5A;
    #1;
    check("exec_rst_phase", 32'(phase), 32'h1);
    check("exec_rst_regs", {8'(A), 8'(B), 2'(OpCode), 8'(result_q), 5'(flags_q), 1'(done)}, 32'h0);
    check("exec_rst_display", 32'(display), 32'h5A);
    press(8'h44);
    check("after_rst_partial", {28'(phase), 4'(done)}, {28'h2, 4'h0});

    repeat (4) @(posedge clk);
    #1 check("sb_drain", 32'(exp_q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/alu_operand_sequencer.md
# alu_operand_sequencer

Sequential front-end controller for the M-bit ALU. It collects operand A, operand B and the 2-bit OpCode from a shared data input, one step per `enter` press. It drives those values into the ALU, then captures the ALU's Result and 5-bit Flags into output registers. It sits between the board-level input logic (switches, debounced buttons) and the combinational ALU, and supplies what the display path shows.

## Interface
- `M`, default 8: operand and result width; must match the ALU's M.

- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `data_in` in M: operand/opcode source; in the opcode step only `data_in[1:0]` is used.
- `enter` in 1: advance request, debounced level; rising-edge detected internally.
- `undo` in 1: step-back request, debounced level; rising-edge detected internally.
- `alu_result` in M: Result from the ALU.
- `alu_flags` in 5: Flags from the ALU as {N,Z,C,V,P}.
- `A` out M: registered operand A to the ALU.
- `B` out M: registered operand B to the ALU.
- `OpCode` out 2: registered opcode to the ALU (00 sub, 01 add, 10 or, 11 and).
- `result_q` out M: captured Result.
- `flags_q` out 5: captured Flags.
- `display` out M: value for the display driver.
- `phase` out 4: one-hot step indicator {SHOW, WAIT_OP, WAIT_B, WAIT_A}; all zero in EXEC.
- `done` out 1: high while `result_q`/`flags_q` hold a fresh result.

## Operation
- Edge detection: registered copies of `enter`/`undo`; an event is current-high AND previous-low. A held input yields one event. Copies reset to 0, so an input already high when reset releases produces one event.
- If enter and undo events occur in the same cycle, both are ignored.
- States, transitions and actions:
  - WAIT_A: enter → A<=data_in, go to WAIT_B. Undo is ignored.
  - WAIT_B: enter → B<=data_in, go to WAIT_OP. Undo → WAIT_A.
  - WAIT_OP: enter → OpCode<=data_in[1:0], go to EXEC. Undo → WAIT_B.
  - EXEC (one cycle, unconditional): result_q<=alu_result, flags_q<=alu_flags, done<=1, go to SHOW. Enter and undo events in EXEC are discarded.
  - SHOW: enter → done<=0, next step per CHAIN_RESULT_EN. Undo → done<=0, go to WAIT_OP.
- A, B and OpCode hold their values until overwritten. Undo does not clear any register.
- display:
  - WAIT_A/WAIT_B: data_in (live preview).
  - WAIT_OP: {M-2 zeros, data_in[1:0]}.
  - EXEC/SHOW: result_q.
- No arithmetic is performed in this block. Widths pass through unchanged; flags are stored verbatim.

## Timing
- Reset, applied in any state including mid-sequence or EXEC, takes effect at the next clk edge:
  - state WAIT_A;
  - A, B, OpCode, result_q, flags_q = 0;
  - done = 0;
  - phase = 4'b0001;
  - display = data_in.
- Enter rising at edge n is sampled at n; the state and loaded register update at edge n+1.
- From the enter event in WAIT_OP (sampled at edge n):
  - OpCode is valid and the state is EXEC after edge n+1;
  - result_q, flags_q and done=1 are valid after edge n+2.
- The ALU is combinational and gets one full cycle in EXEC to settle on the new OpCode.
- Minimum time per step: two cycles of enter (high, then low) to create the next event.

## Configuration
- `CHAIN_RESULT_EN` defined: enter in SHOW loads A<=result_q and goes to WAIT_B, accumulator-style chaining.
- `CHAIN_RESULT_EN` undefined: enter in SHOW goes to WAIT_A; A is unchanged.

## Test plan
- Reset, then enter with 8'h05, 8'h03 and opcode 2'b00 → two cycles after the third event: result_q=8'h02, flags_q=5'b00001, done=1, phase=4'b1000.
- A=8'h7F, B=8'h01, op 01 → result_q=8'h80, flags_q=5'b10011. Then A=8'h03, B=8'h05, op 00 → result_q=8'hFE, flags_q=5'b10101.
- A=8'hF0, B=8'h0F, op 11 → result_q=8'h00, flags_q=5'b01000. Hold enter high for 10 cycles in WAIT_A → exactly one advance.
- In WAIT_OP, undo → WAIT_B; enter 8'h09 → B=8'h09 and A retained. Enter and undo rising in the same cycle → state unchanged.
- Assert reset during EXEC → next cycle: WAIT_A, all registers 0, done=0. Only a full sequence afterwards produces a result.
- With CHAIN_RESULT_EN: after 5-3=2, enter in SHOW → A=8'h02, state WAIT_B. Then B=8'h04, op 01 → result_q=8'h06. Without the macro → state WAIT_A, A=8'h05.
